// File: rtl/i2c_tx_arbiter_if.sv
// Bundle between the requesting clients, the round-robin arbiter and the shared I2C master TX engine.
// slave = arbiter side, master = client/engine side.
interface i2c_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [NUM_REQ-1:0]   err;
  logic                 m_start;
  logic [6:0]           m_addr;
  logic [7:0]           m_data;
  logic                 m_busy;
  logic                 arb_busy;

  modport slave (
    input  req, req_addr, req_data, m_busy,
    output gnt, done, err, m_start, m_addr, m_data, arb_busy
  );

  modport master (
    output req, req_addr, req_data, m_busy,
    input  gnt, done, err, m_start, m_addr, m_data, arb_busy
  );
endinterface

// File: rtl/i2c_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master TX engine among NUM_REQ clients.
// Optional transfer watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no transfer; arbitrate among req starting at rr_ptr
// S_LAUNCH | m_start high, waiting for the master to raise busy
// S_XFER   | master busy; waiting for busy to fall
// S_DONE   | done (or err) pulse and gnt visible; back to IDLE next edge
module i2c_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_tx_arbiter_if.slave   bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_XFER, S_DONE} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_m_start;
  logic [6:0]         r_m_addr;
  logic [7:0]         r_m_data;
  logic               r_arb_busy;
  logic [IW-1:0]      r_win;
  logic [IW-1:0]      r_rr_ptr;

  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [NUM_REQ-1:0] w_onehot;
  logic [6:0]         w_addr;
  logic [7:0]         w_data;
  logic [IW-1:0]      w_next_ptr;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_REQ-1:0] r_err;
  logic [TW-1:0]      r_tmo_cnt;
`endif

  // First set request at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int v_idx;
    v_idx    = 0;
    w_found  = 1'b0;
    w_win    = '0;
    w_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req[v_idx]) begin
        w_found = 1'b1;
        w_win   = IW'(v_idx);
      end
    end
    w_onehot[w_win] = w_found;
    w_addr          = bus.req_addr[7*int'(w_win) +: 7];
    w_data          = bus.req_data[8*int'(w_win) +: 8];
  end

  assign w_next_ptr = (r_win == IW'(NUM_REQ - 1)) ? '0 : IW'(r_win + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_done     <= '0;
      r_m_start  <= 1'b0;
      r_m_addr   <= '0;
      r_m_data   <= '0;
      r_arb_busy <= 1'b0;
      r_win      <= '0;
      r_rr_ptr   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_err      <= '0;
      r_tmo_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt      <= w_onehot;
            r_win      <= w_win;
            r_m_addr   <= w_addr;
            r_m_data   <= w_data;
            r_m_start  <= 1'b1;
            r_arb_busy <= 1'b1;
            r_state    <= S_LAUNCH;
`ifdef I2C_ARB_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
          end
        end
        S_LAUNCH: begin
`ifdef I2C_ARB_TIMEOUT_EN
          // Abort on the cycle the incremented count would reach TIMEOUT_CYCLES.
          if (bus.m_busy) begin
            r_state   <= S_XFER;
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_m_start <= 1'b0;
            r_err     <= r_gnt;
            r_state   <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`else
          if (bus.m_busy) r_state <= S_XFER;
`endif
        end
        S_XFER: begin
          if (!bus.m_busy) begin
            r_m_start <= 1'b0;
            r_done    <= r_gnt;
            r_state   <= S_DONE;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_m_start <= 1'b0;
            r_err     <= r_gnt;
            r_state   <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_gnt      <= '0;
          r_done     <= '0;
          r_arb_busy <= 1'b0;
          r_rr_ptr   <= w_next_ptr;
          r_state    <= S_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
          r_err      <= '0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.m_start  = r_m_start;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_data   = r_m_data;
  assign bus.arb_busy = r_arb_busy;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = '0;
`endif
endmodule

// File: tb/tb_i2c_tx_arbiter.sv
// Directed bench for i2c_tx_arbiter: vector table of single transfers plus hand-written
// sequences for reset, round-robin, late request, data stability and timeout.
module tb_i2c_tx_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  i2c_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  i2c_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [6:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n_bad;
    logic [3:0] exp_rr [5];

    // Client fields: addr 20/50/2A/7F, data 11/A5/5A/C3. Expected winners follow rr_ptr from reset.
    vecs[0] = '{req: 4'b0010, gnt: 4'b0010, addr: 7'h50, data: 8'hA5};
    vecs[1] = '{req: 4'b1111, gnt: 4'b0100, addr: 7'h2A, data: 8'h5A};
    vecs[2] = '{req: 4'b0011, gnt: 4'b0001, addr: 7'h20, data: 8'h11};
    vecs[3] = '{req: 4'b1001, gnt: 4'b1000, addr: 7'h7F, data: 8'hC3};
    vecs[4] = '{req: 4'b0100, gnt: 4'b0100, addr: 7'h2A, data: 8'h5A};
    vecs[5] = '{req: 4'b0110, gnt: 4'b0010, addr: 7'h50, data: 8'hA5};
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;

    rst_n        = 1'b0;
    bus.req      = '0;
    bus.m_busy   = 1'b0;
    bus.req_addr = {7'h7F, 7'h2A, 7'h50, 7'h20};
    bus.req_data = {8'hC3, 8'h5A, 8'hA5, 8'h11};
    tick();
    chk("reset gnt", 32'(bus.gnt), 0);
    chk("reset m_start", 32'(bus.m_start), 0);
    chk("reset arb_busy", 32'(bus.arb_busy), 0);
    chk("reset m_addr", 32'(bus.m_addr), 0);
    chk("reset m_data", 32'(bus.m_data), 0);
    rst_n = 1'b1;
    tick();

    // Table of single transfers, each with a 3-cycle busy pulse from the master model.
    for (int v = 0; v < 6; v++) begin
      bus.req = vecs[v].req;
      tick();
      chk($sformatf("v%0d gnt", v), 32'(bus.gnt), 32'(vecs[v].gnt));
      chk($sformatf("v%0d m_start", v), 32'(bus.m_start), 1);
      chk($sformatf("v%0d m_addr", v), 32'(bus.m_addr), 32'(vecs[v].addr));
      chk($sformatf("v%0d m_data", v), 32'(bus.m_data), 32'(vecs[v].data));
      chk($sformatf("v%0d arb_busy", v), 32'(bus.arb_busy), 1);
      bus.m_busy = 1'b1;
      tick(); tick(); tick();
      chk($sformatf("v%0d xfer done", v), 32'(bus.done), 0);
      chk($sformatf("v%0d xfer m_start", v), 32'(bus.m_start), 1);
      bus.m_busy = 1'b0;
      tick();
      chk($sformatf("v%0d done", v), 32'(bus.done), 32'(vecs[v].gnt));
      chk($sformatf("v%0d done gnt", v), 32'(bus.gnt), 32'(vecs[v].gnt));
      chk($sformatf("v%0d done m_start", v), 32'(bus.m_start), 0);
      chk($sformatf("v%0d err", v), 32'(bus.err), 0);
      bus.req = '0;
      tick();
      chk($sformatf("v%0d idle gnt", v), 32'(bus.gnt), 0);
      chk($sformatf("v%0d idle done", v), 32'(bus.done), 0);
      chk($sformatf("v%0d idle arb_busy", v), 32'(bus.arb_busy), 0);
    end

    // Reset mid-XFER; rr_ptr was 2, so a following 1111 request must start at client 0.
    bus.req = 4'b0100;
    tick();
    bus.m_busy = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst gnt", 32'(bus.gnt), 0);
    chk("midrst done", 32'(bus.done), 0);
    chk("midrst err", 32'(bus.err), 0);
    chk("midrst m_start", 32'(bus.m_start), 0);
    chk("midrst m_addr", 32'(bus.m_addr), 0);
    chk("midrst m_data", 32'(bus.m_data), 0);
    chk("midrst arb_busy", 32'(bus.arb_busy), 0);
    bus.req    = '0;
    bus.m_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Persistent 1111: grants 0,1,2,3,0, each with one IDLE sample after the done cycle.
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      b = 0;
      do begin
        tick();
        b++;
      end while (bus.gnt == '0 && b < 6);
      chk($sformatf("rr%0d gnt", i), 32'(bus.gnt), 32'(exp_rr[i]));
      chk($sformatf("rr%0d wait", i), 32'(b), 32'((i == 0) ? 1 : 2));
      bus.m_busy = 1'b1;
      tick(); tick();
      chk($sformatf("rr%0d hold gnt", i), 32'(bus.gnt), 32'(exp_rr[i]));
      bus.m_busy = 1'b0;
      tick();
      chk($sformatf("rr%0d done", i), 32'(bus.done), 32'(exp_rr[i]));
    end
    bus.req = '0;
    tick();

    // Late request, data change after grant, and winner dropping req mid-transfer. rr_ptr=1.
    bus.req = 4'b0001;
    tick();
    chk("late gnt0", 32'(bus.gnt), 4'b0001);
    bus.m_busy = 1'b1;
    tick();
    bus.req = 4'b0101;
    bus.req_data[7:0] = 8'h3C;
    tick(); tick();
    chk("late hold gnt", 32'(bus.gnt), 4'b0001);
    chk("stable m_data", 32'(bus.m_data), 8'h11);
    bus.req = 4'b0100;
    tick();
    chk("drop gnt", 32'(bus.gnt), 4'b0001);
    bus.m_busy = 1'b0;
    tick();
    chk("drop done", 32'(bus.done), 4'b0001);
    chk("stable m_data done", 32'(bus.m_data), 8'h11);
    tick();
    chk("late idle gnt", 32'(bus.gnt), 0);
    tick();
    chk("late gnt2", 32'(bus.gnt), 4'b0100);
    chk("late m_data2", 32'(bus.m_data), 8'h5A);
    bus.m_busy = 1'b1;
    tick();
    bus.m_busy = 1'b0;
    tick();
    chk("late done2", 32'(bus.done), 4'b0100);
    bus.req = '0;
    bus.req_data[7:0] = 8'h11;
    tick();

    // Master never raises busy. rr_ptr=3, so client 0 wins.
    bus.req = 4'b0001;
    tick();
    chk("tmo gnt", 32'(bus.gnt), 4'b0001);
    n_bad = 0;
`ifdef I2C_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      if (bus.err != '0 || bus.m_start != 1'b1 || bus.done != '0) n_bad++;
    end
    chk("tmo early err cycles", 32'(n_bad), 0);
    tick();
    chk("tmo err", 32'(bus.err), 4'b0001);
    chk("tmo done", 32'(bus.done), 0);
    chk("tmo m_start", 32'(bus.m_start), 0);
    chk("tmo gnt hold", 32'(bus.gnt), 4'b0001);
    bus.req = '0;
    tick();
    chk("tmo idle err", 32'(bus.err), 0);
    chk("tmo idle gnt", 32'(bus.gnt), 0);
    chk("tmo idle arb_busy", 32'(bus.arb_busy), 0);
`else
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.err != '0 || bus.done != '0) n_bad++;
    end
    chk("notmo err cycles", 32'(n_bad), 0);
    chk("notmo gnt", 32'(bus.gnt), 4'b0001);
    chk("notmo m_start", 32'(bus.m_start), 1);
    chk("notmo arb_busy", 32'(bus.arb_busy), 1);
    bus.req = '0;
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("notmo recover arb_busy", 32'(bus.arb_busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
